// File: rtl/l2_port_arbiter_pkg.sv
// l2_port_arbiter_pkg
// Purpose : bus widths of the L1/L2 cache hierarchy, the L2 request-kind
//           type and a small helper that resolves which kind one L1 is
//           asking for when it raises several request lines at once.
// Ports   : none (package).
package l2_port_arbiter_pkg;

  localparam int ADDRESS_WIDTH          = 32;
  localparam int DATA_WIDTH             = 32;
  localparam int MAIN_MEMORY_DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    L2_RD = 2'd0,
    L2_WR = 2'd1,
    L2_WB = 2'd2
  } l2_req_kind_t;

  // Write-back beats write beats read. Read is the fallback because the
  // caller only asks once the requester is known to be pending.
  function automatic l2_req_kind_t pick_kind(input logic i_wr, input logic i_wb);
    l2_req_kind_t w_kind;
    if (i_wb) begin
      w_kind = L2_WB;
    end else if (i_wr) begin
      w_kind = L2_WR;
    end else begin
      w_kind = L2_RD;
    end
    return w_kind;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if
// Purpose : bundles the L1-side request/response lines and the L2-side port
//           of the L2 port arbiter.
// Modports: slave  - the arbiter (takes L1 requests and L2 completions,
//                    drives the L2 request port, L1 strobes and status).
//           master - the environment (L1 FSM array plus L2 cache FSM).
interface l2_port_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import l2_port_arbiter_pkg::*;

  // L1 side
  logic [NUM_REQ-1:0]                        req_read;
  logic [NUM_REQ-1:0]                        req_write;
  logic [NUM_REQ-1:0]                        req_wb;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0]          req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]             req_wdata;
  logic [NUM_REQ*MAIN_MEMORY_DATA_WIDTH-1:0] req_wb_data;
  logic [NUM_REQ-1:0]                        resp_ready;
  logic [NUM_REQ-1:0]                        resp_write_verified;
  logic [NUM_REQ-1:0]                        resp_wb_verified;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0]         resp_read_data;
  // L2 side
  logic [ADDRESS_WIDTH-1:0]                  l2_addr;
  logic                                      l2_read_request;
  logic                                      l2_write_request;
  logic                                      l2_write_back_request;
  logic [DATA_WIDTH-1:0]                     l2_write_data;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0]         l2_write_back_data;
  logic                                      l2_ready;
  logic                                      l2_write_verified;
  logic                                      l2_write_back_verified;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0]         l2_read_data;
  // status
  logic                                      grant_valid;
  logic [$clog2(NUM_REQ)-1:0]                grant_id;
  logic                                      timeout_err;

  modport slave (
    input  req_read, req_write, req_wb, req_addr, req_wdata, req_wb_data,
    input  l2_ready, l2_write_verified, l2_write_back_verified, l2_read_data,
    output l2_addr, l2_read_request, l2_write_request, l2_write_back_request,
    output l2_write_data, l2_write_back_data,
    output resp_ready, resp_write_verified, resp_wb_verified, resp_read_data,
    output grant_valid, grant_id, timeout_err
  );

  modport master (
    output req_read, req_write, req_wb, req_addr, req_wdata, req_wb_data,
    output l2_ready, l2_write_verified, l2_write_back_verified, l2_read_data,
    input  l2_addr, l2_read_request, l2_write_request, l2_write_back_request,
    input  l2_write_data, l2_write_back_data,
    input  resp_ready, resp_write_verified, resp_wb_verified, resp_read_data,
    input  grant_valid, grant_id, timeout_err
  );

endinterface

// File: rtl/l2_port_arbiter_rr_priority_pick.sv
// l2_port_arbiter_rr_priority_pick
// Purpose : combinational round-robin picker. Returns the first set bit of
//           i_pending at or after i_ptr, wrapping past NUM_REQ-1 to 0.
// Ports   : i_pending - request vector
//           i_ptr     - index with highest priority this round
//           o_found   - any request pending
//           o_id      - winning index (i_ptr when nothing is pending)
module l2_port_arbiter_rr_priority_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_pending,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_id
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] w_idx;

  assign o_found = |i_pending;

  // Walk offsets from farthest to nearest so the nearest pending index is
  // the last one written. NUM_REQ is a power of two, so the ID_W-bit add
  // wraps modulo NUM_REQ by itself.
  always_comb begin
    o_id  = i_ptr;
    w_idx = i_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = i_ptr + ID_W'(k);
      o_id  = i_pending[w_idx] ? w_idx : o_id;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Purpose : shares the single L2 request port between NUM_REQ L1 cache FSMs.
//           In IDLE one pending L1 is picked round-robin and its kind,
//           address and data are latched. In BUSY the request is held until
//           the L2 returns the matching completion or the watchdog expires.
//           RELEASE lasts one cycle: the L2 request drops and the winner
//           gets its 1-cycle completion strobe.
// Ports   : clk   - clock
//           reset - asynchronous, active-high reset
//           bus   - l2_port_arbiter_if.slave (L1 requests/strobes, L2 port,
//                   grant_valid / grant_id / timeout_err status)
module l2_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  l2_port_arbiter_if.slave bus
);
  import l2_port_arbiter_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  // r_wd counts completed BUSY cycles, so it reads TIMEOUT_CYCLES-1 during
  // the last BUSY cycle the watchdog allows.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                            r_state, w_state_nxt;
  l2_req_kind_t                      r_kind, w_kind_nxt;
  logic [ID_W-1:0]                   r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]                   r_grant_id, w_grant_id_nxt;
  logic [WD_W-1:0]                   r_wd, w_wd_nxt;
  logic                              r_grant_valid, w_grant_valid_nxt;
  logic                              r_timeout_err, w_timeout_err_nxt;
  logic                              r_rd_req, w_rd_req_nxt;
  logic                              r_wr_req, w_wr_req_nxt;
  logic                              r_wb_req, w_wb_req_nxt;
  logic [ADDRESS_WIDTH-1:0]          r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]             r_wdata, w_wdata_nxt;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] r_wbdata, w_wbdata_nxt;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [NUM_REQ-1:0]                r_resp_rd, w_resp_rd_nxt;
  logic [NUM_REQ-1:0]                r_resp_wr, w_resp_wr_nxt;
  logic [NUM_REQ-1:0]                r_resp_wb, w_resp_wb_nxt;

  logic [NUM_REQ-1:0] w_pending;
  logic [NUM_REQ-1:0] w_winner_oh;
  logic               w_found;
  logic [ID_W-1:0]    w_pick_id;
  l2_req_kind_t       w_pick_kind;
  logic               w_done;
  logic               w_expired;

  assign w_pending = bus.req_read | bus.req_write | bus.req_wb;

  l2_port_arbiter_rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_pending (w_pending),
    .i_ptr     (r_ptr),
    .o_found   (w_found),
    .o_id      (w_pick_id)
  );

  assign w_pick_kind = pick_kind(bus.req_write[w_pick_id], bus.req_wb[w_pick_id]);

  // Only the completion that matches the latched kind ends the transaction.
  assign w_done = ((r_kind == L2_RD) && bus.l2_ready) ||
                  ((r_kind == L2_WR) && bus.l2_write_verified) ||
                  ((r_kind == L2_WB) && bus.l2_write_back_verified);

  assign w_expired   = WD_EN && (r_wd == WD_LAST);
  assign w_winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state_nxt       = r_state;
    w_kind_nxt        = r_kind;
    w_ptr_nxt         = r_ptr;
    w_grant_id_nxt    = r_grant_id;
    w_wd_nxt          = r_wd;
    w_grant_valid_nxt = r_grant_valid;
    w_timeout_err_nxt = r_timeout_err;
    w_rd_req_nxt      = r_rd_req;
    w_wr_req_nxt      = r_wr_req;
    w_wb_req_nxt      = r_wb_req;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_wbdata_nxt      = r_wbdata;
    w_rdata_nxt       = r_rdata;
    w_resp_rd_nxt     = {NUM_REQ{1'b0}};
    w_resp_wr_nxt     = {NUM_REQ{1'b0}};
    w_resp_wb_nxt     = {NUM_REQ{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt       = S_BUSY;
          w_kind_nxt        = w_pick_kind;
          w_ptr_nxt         = w_pick_id + ID_W'(1);
          w_grant_id_nxt    = w_pick_id;
          w_wd_nxt          = {WD_W{1'b0}};
          w_grant_valid_nxt = 1'b1;
          w_rd_req_nxt      = (w_pick_kind == L2_RD);
          w_wr_req_nxt      = (w_pick_kind == L2_WR);
          w_wb_req_nxt      = (w_pick_kind == L2_WB);
          w_addr_nxt        = bus.req_addr[w_pick_id*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          w_wdata_nxt       = bus.req_wdata[w_pick_id*DATA_WIDTH +: DATA_WIDTH];
          w_wbdata_nxt      = bus.req_wb_data[w_pick_id*MAIN_MEMORY_DATA_WIDTH +: MAIN_MEMORY_DATA_WIDTH];
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        // A completion arriving on the watchdog's last cycle still counts.
        if (w_done || w_expired) begin
          w_state_nxt       = S_RELEASE;
          w_grant_valid_nxt = 1'b0;
          w_rd_req_nxt      = 1'b0;
          w_wr_req_nxt      = 1'b0;
          w_wb_req_nxt      = 1'b0;
          if (w_done) begin
            w_resp_rd_nxt = (r_kind == L2_RD) ? w_winner_oh : {NUM_REQ{1'b0}};
            w_resp_wr_nxt = (r_kind == L2_WR) ? w_winner_oh : {NUM_REQ{1'b0}};
            w_resp_wb_nxt = (r_kind == L2_WB) ? w_winner_oh : {NUM_REQ{1'b0}};
            w_rdata_nxt   = (r_kind == L2_RD) ? bus.l2_read_data : r_rdata;
          end else begin
            w_timeout_err_nxt = 1'b1;
          end
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset drops the L2 request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_kind        <= L2_RD;
      r_ptr         <= {ID_W{1'b0}};
      r_grant_id    <= {ID_W{1'b0}};
      r_wd          <= {WD_W{1'b0}};
      r_grant_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rd_req      <= 1'b0;
      r_wr_req      <= 1'b0;
      r_wb_req      <= 1'b0;
      r_addr        <= {ADDRESS_WIDTH{1'b0}};
      r_wdata       <= {DATA_WIDTH{1'b0}};
      r_wbdata      <= {MAIN_MEMORY_DATA_WIDTH{1'b0}};
      r_rdata       <= {MAIN_MEMORY_DATA_WIDTH{1'b0}};
      r_resp_rd     <= {NUM_REQ{1'b0}};
      r_resp_wr     <= {NUM_REQ{1'b0}};
      r_resp_wb     <= {NUM_REQ{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_kind        <= w_kind_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_wd          <= w_wd_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_rd_req      <= w_rd_req_nxt;
      r_wr_req      <= w_wr_req_nxt;
      r_wb_req      <= w_wb_req_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wbdata      <= w_wbdata_nxt;
      r_rdata       <= w_rdata_nxt;
      r_resp_rd     <= w_resp_rd_nxt;
      r_resp_wr     <= w_resp_wr_nxt;
      r_resp_wb     <= w_resp_wb_nxt;
    end
  end

  assign bus.l2_addr               = r_addr;
  assign bus.l2_read_request       = r_rd_req;
  assign bus.l2_write_request      = r_wr_req;
  assign bus.l2_write_back_request = r_wb_req;
  assign bus.l2_write_data         = r_wdata;
  assign bus.l2_write_back_data    = r_wbdata;
  assign bus.resp_ready            = r_resp_rd;
  assign bus.resp_write_verified   = r_resp_wr;
  assign bus.resp_wb_verified      = r_resp_wb;
  assign bus.resp_read_data        = r_rdata;
  assign bus.grant_valid           = r_grant_valid;
  assign bus.grant_id              = r_grant_id;
  assign bus.timeout_err           = r_timeout_err;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter
// Purpose : self-checking bench for l2_port_arbiter. A transaction-level
//           model (owner / age / cool-down) predicts every output each
//           cycle; directed scenarios pin the model with literal values;
//           a randomized phase drives requests and L2 completions.
module tb_l2_port_arbiter;
  import l2_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int MW = MAIN_MEMORY_DATA_WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  l2_port_arbiter_if #(.NUM_REQ(N)) bus ();

  l2_port_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int             m_owner;   // -1: port free
  int             m_kind;    // 0 read, 1 write, 2 write-back
  int             m_next;    // first requester to consider next time
  int             m_age;     // BUSY cycles elapsed for the owner
  bit             m_cool;    // release cycle in progress
  logic [AW-1:0]  e_addr;
  logic [DW-1:0]  e_wdata;
  logic [MW-1:0]  e_wbdata, e_rdata;
  logic [N-1:0]   e_rr, e_wv, e_wbv;
  logic [1:0]     e_gid;
  logic           e_to;

  task automatic model_reset();
    m_owner = -1; m_kind = 0; m_next = 0; m_age = 0; m_cool = 1'b0;
    e_addr = '0; e_wdata = '0; e_wbdata = '0; e_rdata = '0;
    e_rr = '0; e_wv = '0; e_wbv = '0; e_gid = 2'd0; e_to = 1'b0;
  endtask

  task automatic model_step();
    int c;
    bit done;
    if (reset) begin
      model_reset();
      return;
    end
    e_rr = '0; e_wv = '0; e_wbv = '0;
    if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_next + k) % N;
        if (bus.req_read[c] | bus.req_write[c] | bus.req_wb[c]) begin
          m_owner  = c;
          m_kind   = bus.req_wb[c] ? 2 : (bus.req_write[c] ? 1 : 0);
          e_addr   = bus.req_addr[c*AW +: AW];
          e_wdata  = bus.req_wdata[c*DW +: DW];
          e_wbdata = bus.req_wb_data[c*MW +: MW];
          e_gid    = 2'(c);
          m_next   = (c + 1) % N;
          m_age    = 0;
          break;
        end
      end
    end else begin
      m_age++;
      done = (m_kind == 0 && bus.l2_ready) || (m_kind == 1 && bus.l2_write_verified) ||
             (m_kind == 2 && bus.l2_write_back_verified);
      if (done) begin
        if (m_kind == 0) begin
          e_rr[m_owner] = 1'b1;
          e_rdata = bus.l2_read_data;
        end else if (m_kind == 1) begin
          e_wv[m_owner] = 1'b1;
        end else begin
          e_wbv[m_owner] = 1'b1;
        end
        m_owner = -1; m_cool = 1'b1;
      end else if (m_age == TO) begin
        e_to = 1'b1; m_owner = -1; m_cool = 1'b1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model advances on every rising edge using the inputs the DUT samples.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Single compare process: all outputs against the model, every cycle.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cmp_l2_read_request",  bus.l2_read_request,       (m_owner >= 0) && (m_kind == 0));
      chk("cmp_l2_write_request", bus.l2_write_request,      (m_owner >= 0) && (m_kind == 1));
      chk("cmp_l2_wb_request",    bus.l2_write_back_request, (m_owner >= 0) && (m_kind == 2));
      chk("cmp_grant_valid",      bus.grant_valid,           m_owner >= 0);
      chk("cmp_grant_id",         bus.grant_id,              e_gid);
      chk("cmp_l2_addr",          bus.l2_addr,               e_addr);
      chk("cmp_l2_write_data",    bus.l2_write_data,         e_wdata);
      chk("cmp_l2_wb_data",       bus.l2_write_back_data,    e_wbdata);
      chk("cmp_resp_ready",       bus.resp_ready,            e_rr);
      chk("cmp_resp_wv",          bus.resp_write_verified,   e_wv);
      chk("cmp_resp_wbv",         bus.resp_wb_verified,      e_wbv);
      chk("cmp_resp_read_data",   bus.resp_read_data,        e_rdata);
      chk("cmp_timeout_err",      bus.timeout_err,           e_to);
    end
  end

  task automatic clear_inputs();
    bus.req_read = '0; bus.req_write = '0; bus.req_wb = '0;
    bus.l2_ready = 1'b0; bus.l2_write_verified = 1'b0; bus.l2_write_back_verified = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [MW-1:0] blk;
    int            gids[4];
    int            ng;
    int            nh;
    logic          prev;

    clear_inputs();
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_wb_data = '0; bus.l2_read_data = '0;
    model_reset();
    #1;
    reset = 1'b1;
    #1;
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant_valid", bus.grant_valid, 1'b0);
    chk("rst_l2_read_request", bus.l2_read_request, 1'b0);
    chk("rst_resp_read_data", bus.resp_read_data, 128'h0);
    chk("rst_timeout_err", bus.timeout_err, 1'b0);
    reset = 1'b0;

    // Single read from L1 2; L2 answers in the third request cycle.
    blk = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    bus.req_addr[2*AW +: AW] = 32'h8000_0040;
    bus.req_read[2] = 1'b1;
    @(negedge clk);
    chk("t1_req_cycle1", bus.l2_read_request, 1'b1);
    chk("t1_addr", bus.l2_addr, 32'h8000_0040);
    chk("t1_grant_id", bus.grant_id, 2'd2);
    bus.req_read[2] = 1'b0;
    @(negedge clk);
    chk("t1_req_cycle2", bus.l2_read_request, 1'b1);
    @(negedge clk);
    chk("t1_req_cycle3", bus.l2_read_request, 1'b1);
    bus.l2_read_data = blk;
    bus.l2_ready = 1'b1;
    @(negedge clk);
    bus.l2_ready = 1'b0;
    chk("t1_req_dropped", bus.l2_read_request, 1'b0);
    chk("t1_resp_ready", bus.resp_ready, 4'b0100);
    chk("t1_resp_data", bus.resp_read_data, blk);
    @(negedge clk);
    chk("t1_strobe_one_cycle", bus.resp_ready, 4'b0000);

    // Continuous reads from L1 0,1,3 starting right after reset.
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    bus.req_read = 4'b1011;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) gids[i] = 99;
    ng = 0;
    prev = 1'b0;
    for (int t = 0; t < 40 && ng < 4; t++) begin
      @(negedge clk);
      if (bus.l2_read_request && !prev) begin
        gids[ng] = int'(bus.grant_id);
        ng++;
      end
      prev = bus.l2_read_request;
      bus.l2_ready = bus.l2_read_request;
    end
    chk("t2_grant_count", ng, 4);
    chk("t2_grant0", gids[0], 0);
    chk("t2_grant1", gids[1], 1);
    chk("t2_grant2", gids[2], 3);
    chk("t2_grant3", gids[3], 0);

    // L1 1 raises write-back and read together.
    do_reset();
    bus.req_wb_data[1*MW +: MW] = 128'h5555_aaaa_0000_ffff_1234_5678_9abc_def0;
    bus.req_wb[1] = 1'b1;
    bus.req_read[1] = 1'b1;
    @(negedge clk);
    chk("t3_wb_first", bus.l2_write_back_request, 1'b1);
    chk("t3_no_read_yet", bus.l2_read_request, 1'b0);
    chk("t3_wb_data", bus.l2_write_back_data, 128'h5555_aaaa_0000_ffff_1234_5678_9abc_def0);
    bus.l2_write_back_verified = 1'b1;
    @(negedge clk);
    bus.l2_write_back_verified = 1'b0;
    chk("t3_wb_verified", bus.resp_wb_verified, 4'b0010);
    bus.req_wb[1] = 1'b0;
    @(negedge clk);
    chk("t3_idle_gap", bus.l2_read_request, 1'b0);
    @(negedge clk);
    chk("t3_read_after_wb", bus.l2_read_request, 1'b1);
    chk("t3_read_grant_id", bus.grant_id, 2'd1);
    bus.l2_ready = 1'b1;
    @(negedge clk);
    bus.l2_ready = 1'b0;
    bus.req_read[1] = 1'b0;
    chk("t3_read_done", bus.resp_ready, 4'b0010);

    // Wrong-kind completion during a read is ignored.
    @(negedge clk);
    bus.req_read[3] = 1'b1;
    @(negedge clk);
    bus.req_read[3] = 1'b0;
    chk("t4_busy_read", bus.l2_read_request, 1'b1);
    bus.l2_write_verified = 1'b1;
    @(negedge clk);
    bus.l2_write_verified = 1'b0;
    chk("t4_no_wv_strobe", bus.resp_write_verified, 4'b0000);
    chk("t4_still_busy", bus.l2_read_request, 1'b1);
    bus.l2_read_data = 128'hdead_beef_0000_0001_0000_0002_0000_0003;
    bus.l2_ready = 1'b1;
    @(negedge clk);
    bus.l2_ready = 1'b0;
    chk("t4_read_done", bus.resp_ready, 4'b1000);

    // L2 never answers: watchdog aborts after TO cycles.
    @(negedge clk);
    bus.req_read[0] = 1'b1;
    nh = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus.req_read[0] = 1'b0;
      if (bus.l2_read_request) nh++;
      else break;
    end
    chk("t5_busy_cycles", nh, TO);
    chk("t5_timeout_err", bus.timeout_err, 1'b1);
    chk("t5_no_strobe", {bus.resp_ready, bus.resp_write_verified, bus.resp_wb_verified}, 12'h000);
    @(negedge clk);
    chk("t5_back_idle", bus.grant_valid, 1'b0);
    chk("t5_err_sticky", bus.timeout_err, 1'b1);

    // Reset while BUSY drops the request at once; L1 0 wins afterwards.
    bus.req_read[2] = 1'b1;
    @(negedge clk);
    chk("t6_busy", bus.grant_valid, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_req_dropped", bus.l2_read_request, 1'b0);
    chk("t6_grant_dropped", bus.grant_valid, 1'b0);
    chk("t6_err_cleared", bus.timeout_err, 1'b0);
    bus.req_read = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_first_winner", bus.grant_id, 2'd0);
    chk("t6_first_busy", bus.l2_read_request, 1'b1);

    // Randomized traffic checked by the model.
    do_reset();
    for (int t = 0; t < 1600; t++) begin
      if (t == 800) do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        bus.req_read[i]  = ($urandom_range(0, 3) == 0);
        bus.req_write[i] = ($urandom_range(0, 3) == 0);
        bus.req_wb[i]    = ($urandom_range(0, 3) == 0);
      end
      for (int w = 0; w < N*AW/32; w++) bus.req_addr[w*32 +: 32] = $urandom;
      for (int w = 0; w < N*DW/32; w++) bus.req_wdata[w*32 +: 32] = $urandom;
      for (int w = 0; w < N*MW/32; w++) bus.req_wb_data[w*32 +: 32] = $urandom;
      for (int w = 0; w < MW/32; w++) bus.l2_read_data[w*32 +: 32] = $urandom;
      bus.l2_ready               = ($urandom_range(0, 4) == 0);
      bus.l2_write_verified      = ($urandom_range(0, 4) == 0);
      bus.l2_write_back_verified = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
